// File: rtl/core_dataslot_reader_pkg.sv
// Shared bridge types: dataslot read FSM states, host error codes, request parameters.
package bridge_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRequest  = 3'd1,
        StWaitDone = 3'd2,
        StComplete = 3'd3,
        StRearm    = 3'd4
    } dataslot_rd_state_e;

    localparam logic [2:0] DATASLOT_ERR_NONE = 3'd0;

    typedef struct packed {
        logic [15:0] slot_id;
        logic [31:0] slot_offset;
        logic [31:0] bridge_addr;
        logic [31:0] length;
    } dataslot_param_t;

endpackage

// File: rtl/core_dataslot_read_if.sv
// Level request from a core-side requester (e.g. hiscore loader) to the dataslot reader.
interface core_dataslot_read_if;
    import bridge_pkg::*;

    logic            valid;
    dataslot_param_t param;
    logic            done;

    modport master (output valid, output param, input done);
    modport slave  (input valid, input param, output done);
endinterface

// File: rtl/core_dataslot_reader_timeout_counter.sv
// Loadable down-counter watchdog; expired is high while enabled and the count has run out.
module timeout_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expired
);
    logic [WIDTH-1:0] count_q;

    // Load takes priority; the count parks at zero instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (enable && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign expired = enable && (count_q == '0);
endmodule

// File: rtl/core_dataslot_reader.sv
// Turns a level dataslot-read request into the APF target dataslot read command handshake.
module core_dataslot_reader
    import bridge_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES     = 32'd74_250_000,
    parameter bit          ACK_TIMEOUT_ENABLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    core_dataslot_read_if.slave  core_dataslot_read,
    output logic                 target_dataslot_read,
    output logic [15:0]          target_dataslot_id,
    output logic [31:0]          target_dataslot_slotoffset,
    output logic [31:0]          target_dataslot_bridgeaddr,
    output logic [31:0]          target_dataslot_length,
    input  logic                 target_dataslot_ack,
    input  logic                 target_dataslot_done,
    input  logic [2:0]           target_dataslot_err,
    output logic                 read_error,
    output logic                 busy
);
    localparam bit WdOn = (TIMEOUT_CYCLES != 32'd0);

    dataslot_rd_state_e state_q, state_d;
    dataslot_param_t    param_q;
    logic               read_q, done_q, read_error_q, busy_q;
    logic               capture, err_set, err_clr;
    logic               wd_load, wd_enable, wd_expired_raw, wd_expired;

    timeout_counter #(
        .WIDTH (32)
    ) u_watchdog (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (wd_load),
        .load_value (TIMEOUT_CYCLES),
        .enable     (wd_enable),
        .expired    (wd_expired_raw)
    );

    assign wd_expired = WdOn && wd_expired_raw;

    // Next-state logic; a host done in the same cycle as expiry is honoured over the timeout.
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        wd_load   = 1'b0;
        wd_enable = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (core_dataslot_read.valid) begin
                    capture = 1'b1;
                    err_clr = 1'b1;
                    wd_load = 1'b1;
                    state_d = StRequest;
                end
            end
            StRequest: begin
                wd_enable = ACK_TIMEOUT_ENABLE;
                if (target_dataslot_ack && target_dataslot_done) begin
                    err_set = (target_dataslot_err != DATASLOT_ERR_NONE);
                    state_d = StComplete;
                end else if (target_dataslot_ack) begin
                    state_d = StWaitDone;
                end else if (wd_expired) begin
                    err_set = 1'b1;
                    state_d = StComplete;
                end
            end
            StWaitDone: begin
                wd_enable = 1'b1;
                if (target_dataslot_done) begin
                    err_set = (target_dataslot_err != DATASLOT_ERR_NONE);
                    state_d = StComplete;
                end else if (wd_expired) begin
                    err_set = 1'b1;
                    state_d = StComplete;
                end
            end
            StComplete: state_d = StRearm;
            StRearm: begin
                // Requester must drop valid before another command can start.
                if (!core_dataslot_read.valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            read_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            read_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            read_q  <= (state_d == StRequest);
            done_q  <= (state_d == StComplete);
            busy_q  <= (state_d != StIdle);
            if (err_clr) begin
                read_error_q <= 1'b0;
            end else if (err_set) begin
                read_error_q <= 1'b1;
            end
        end
    end

    // Parameters captured once per accepted request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            param_q <= '0;
        end else if (capture) begin
            param_q <= core_dataslot_read.param;
        end
    end

    assign core_dataslot_read.done    = done_q;
    assign target_dataslot_read       = read_q;
    assign target_dataslot_id         = param_q.slot_id;
    assign target_dataslot_slotoffset = param_q.slot_offset;
    assign target_dataslot_bridgeaddr = param_q.bridge_addr;
    assign target_dataslot_length     = param_q.length;
    assign read_error                 = read_error_q;
    assign busy                       = busy_q;
endmodule

// File: tb/tb_core_dataslot_reader.sv
// Bench for core_dataslot_reader: instance 0 has the watchdog disabled, instance 1 times out at 100.
module tb_core_dataslot_reader;
    import bridge_pkg::*;

    localparam int unsigned TO_CYCLES = 100;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic            valid [2];
    dataslot_param_t param [2];
    logic            ack   [2];
    logic            hdone [2];
    logic [2:0]      herr  [2];

    logic        o_read [2];
    logic [15:0] o_id   [2];
    logic [31:0] o_off  [2];
    logic [31:0] o_addr [2];
    logic [31:0] o_len  [2];
    logic        o_done [2];
    logic        o_rerr [2];
    logic        o_busy [2];

    core_dataslot_read_if rd0 ();
    core_dataslot_read_if rd1 ();
    assign rd0.valid = valid[0];
    assign rd0.param = param[0];
    assign o_done[0] = rd0.done;
    assign rd1.valid = valid[1];
    assign rd1.param = param[1];
    assign o_done[1] = rd1.done;

    core_dataslot_reader #(
        .TIMEOUT_CYCLES     (32'd0),
        .ACK_TIMEOUT_ENABLE (1'b1)
    ) dut0 (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .core_dataslot_read         (rd0),
        .target_dataslot_read       (o_read[0]),
        .target_dataslot_id         (o_id[0]),
        .target_dataslot_slotoffset (o_off[0]),
        .target_dataslot_bridgeaddr (o_addr[0]),
        .target_dataslot_length     (o_len[0]),
        .target_dataslot_ack        (ack[0]),
        .target_dataslot_done       (hdone[0]),
        .target_dataslot_err        (herr[0]),
        .read_error                 (o_rerr[0]),
        .busy                       (o_busy[0])
    );

    core_dataslot_reader #(
        .TIMEOUT_CYCLES     (32'(TO_CYCLES)),
        .ACK_TIMEOUT_ENABLE (1'b1)
    ) dut1 (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .core_dataslot_read         (rd1),
        .target_dataslot_read       (o_read[1]),
        .target_dataslot_id         (o_id[1]),
        .target_dataslot_slotoffset (o_off[1]),
        .target_dataslot_bridgeaddr (o_addr[1]),
        .target_dataslot_length     (o_len[1]),
        .target_dataslot_ack        (ack[1]),
        .target_dataslot_done       (hdone[1]),
        .target_dataslot_err        (herr[1]),
        .read_error                 (o_rerr[1]),
        .busy                       (o_busy[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: request lifetime tracked by age since acceptance and edges since finish.
    typedef struct packed {
        logic            busy;
        logic            read;
        logic            done;
        logic            rerr;
        logic            pending;
        logic            acked;
        dataslot_param_t par;
        logic [31:0]     age;
        logic [31:0]     post;
    } mdl_t;

    mdl_t mdl [2];

    function automatic mdl_t step(input mdl_t s, input int unsigned lim, input logic v,
                                  input dataslot_param_t p, input logic a, input logic d,
                                  input logic [2:0] e);
        mdl_t n;
        logic fin;
        logic ferr;
        n      = s;
        fin    = 1'b0;
        ferr   = 1'b0;
        n.done = 1'b0;
        if (!s.busy) begin
            if (v) begin
                n.busy    = 1'b1;
                n.read    = 1'b1;
                n.rerr    = 1'b0;
                n.pending = 1'b1;
                n.acked   = 1'b0;
                n.par     = p;
                n.age     = 32'd0;
            end
        end else if (s.pending) begin
            n.age = s.age + 32'd1;
            if (!s.acked && a && d) begin
                fin  = 1'b1;
                ferr = (e != 3'd0);
            end else if (!s.acked && a) begin
                n.acked = 1'b1;
                n.read  = 1'b0;
            end else if (s.acked && d) begin
                fin  = 1'b1;
                ferr = (e != 3'd0);
            end else if (lim != 0 && n.age > lim) begin
                fin  = 1'b1;
                ferr = 1'b1;
            end
            if (fin) begin
                n.pending = 1'b0;
                n.read    = 1'b0;
                n.done    = 1'b1;
                n.post    = 32'd0;
                if (ferr) n.rerr = 1'b1;
            end
        end else begin
            n.post = s.post + 32'd1;
            if (n.post >= 32'd2 && !v) n.busy = 1'b0;
        end
        return n;
    endfunction

    // Advance the model on each clock edge; reset clears it immediately.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdl[0] <= '0;
            mdl[1] <= '0;
        end else begin
            mdl[0] <= step(mdl[0], 0, valid[0], param[0], ack[0], hdone[0], herr[0]);
            mdl[1] <= step(mdl[1], TO_CYCLES, valid[1], param[1], ack[1], hdone[1], herr[1]);
        end
    end

    int   rd_rise [2] = '{0, 0};
    int   rd_hi   [2] = '{0, 0};
    int   dn_cnt  [2] = '{0, 0};
    logic prev_rd [2] = '{1'b0, 1'b0};

    // Compare every output against the model and keep event counters, mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("cmp_read%0d", i), 128'(o_read[i]), 128'(mdl[i].read));
            check($sformatf("cmp_done%0d", i), 128'(o_done[i]), 128'(mdl[i].done));
            check($sformatf("cmp_busy%0d", i), 128'(o_busy[i]), 128'(mdl[i].busy));
            check($sformatf("cmp_rerr%0d", i), 128'(o_rerr[i]), 128'(mdl[i].rerr));
            check($sformatf("cmp_par%0d", i), 128'({o_id[i], o_off[i], o_addr[i], o_len[i]}),
                  128'(mdl[i].par));
            if (o_read[i] && !prev_rd[i]) rd_rise[i] <= rd_rise[i] + 1;
            if (o_read[i]) rd_hi[i] <= rd_hi[i] + 1;
            if (o_done[i]) dn_cnt[i] <= dn_cnt[i] + 1;
            prev_rd[i] <= o_read[i];
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_req(input int i, input logic [15:0] id, input logic [31:0] off,
                             input logic [31:0] addr, input logic [31:0] len);
        param[i] = '{slot_id: id, slot_offset: off, bridge_addr: addr, length: len};
        valid[i] = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL sim_time_limit got=expired expected=finish");
        $fatal(1, "time limit");
    end

    int r0, d0, h0, n;

    initial begin
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0;
            param[i] = '0;
            ack[i]   = 1'b0;
            hdone[i] = 1'b0;
            herr[i]  = 3'd0;
        end
        #1 reset_n = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            check("rst_read", 128'(o_read[i]), 128'(0));
            check("rst_done", 128'(o_done[i]), 128'(0));
            check("rst_busy", 128'(o_busy[i]), 128'(0));
            check("rst_rerr", 128'(o_rerr[i]), 128'(0));
            check("rst_par", 128'({o_id[i], o_off[i], o_addr[i], o_len[i]}), 128'(0));
        end
        reset_n = 1'b1;
        repeat (2) tick();

        // Ack/done while idle must be ignored.
        ack[0] = 1'b1; hdone[0] = 1'b1;
        tick();
        ack[0] = 1'b0; hdone[0] = 1'b0;
        tick();
        check("idle_ignore_busy", 128'(o_busy[0]), 128'(0));
        check("idle_ignore_done", 128'(dn_cnt[0]), 128'(0));

        // Nominal: ack after 5 cycles, done 200 cycles later.
        r0 = rd_rise[0]; d0 = dn_cnt[0];
        start_req(0, 16'd2, 32'd0, 32'h1000_1620, 32'h50);
        tick();
        check("nom_read", 128'(o_read[0]), 128'(1));
        check("nom_par", 128'({o_id[0], o_off[0], o_addr[0], o_len[0]}),
              128'({16'd2, 32'd0, 32'h1000_1620, 32'h50}));
        param[0] = '1;
        repeat (4) tick();
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        check("nom_ack_drop", 128'(o_read[0]), 128'(0));
        repeat (199) tick();
        hdone[0] = 1'b1; herr[0] = 3'd0;
        tick();
        hdone[0] = 1'b0;
        check("nom_done", 128'(o_done[0]), 128'(1));
        check("nom_rerr", 128'(o_rerr[0]), 128'(0));
        tick();
        check("nom_done_once", 128'(o_done[0]), 128'(0));
        valid[0] = 1'b0;
        repeat (3) tick();
        check("nom_idle", 128'(o_busy[0]), 128'(0));
        check("nom_done_cnt", 128'(dn_cnt[0] - d0), 128'(1));
        check("nom_cmd_cnt", 128'(rd_rise[0] - r0), 128'(1));
        check("nom_par_held", 128'({o_id[0], o_off[0], o_addr[0], o_len[0]}),
              128'({16'd2, 32'd0, 32'h1000_1620, 32'h50}));

        // Host error: err=2 sets a sticky read_error.
        start_req(0, 16'd2, 32'd0, 32'h1000_1620, 32'h50);
        repeat (2) tick();
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        repeat (3) tick();
        hdone[0] = 1'b1; herr[0] = 3'd2;
        tick();
        hdone[0] = 1'b0; herr[0] = 3'd0;
        check("err_done", 128'(o_done[0]), 128'(1));
        check("err_flag", 128'(o_rerr[0]), 128'(1));
        valid[0] = 1'b0;
        repeat (10) tick();
        check("err_sticky", 128'(o_rerr[0]), 128'(1));

        // Same-cycle ack+done on the first request cycle.
        r0 = rd_rise[0]; h0 = rd_hi[0];
        start_req(0, 16'd7, 32'h100, 32'h2000, 32'h4);
        tick();
        check("err_clear_on_accept", 128'(o_rerr[0]), 128'(0));
        check("same_read", 128'(o_read[0]), 128'(1));
        ack[0] = 1'b1; hdone[0] = 1'b1;
        tick();
        ack[0] = 1'b0; hdone[0] = 1'b0;
        check("same_done", 128'(o_done[0]), 128'(1));
        check("same_read_drop", 128'(o_read[0]), 128'(0));
        valid[0] = 1'b0;
        repeat (3) tick();
        check("same_read_cycles", 128'(rd_hi[0] - h0), 128'(1));
        check("same_cmd_cnt", 128'(rd_rise[0] - r0), 128'(1));

        // Timeout on instance 1: host never acks.
        r0 = rd_rise[1]; h0 = rd_hi[1]; d0 = dn_cnt[1];
        start_req(1, 16'd5, 32'h40, 32'h3000, 32'h10);
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_done[1] && n < 300);
        check("to_latency", 128'(n), 128'(TO_CYCLES + 2));
        check("to_read_cycles", 128'(rd_hi[1] - h0), 128'(TO_CYCLES + 1));
        check("to_read_drop", 128'(o_read[1]), 128'(0));
        check("to_rerr", 128'(o_rerr[1]), 128'(1));
        ack[1] = 1'b1;
        tick();
        ack[1] = 1'b0; hdone[1] = 1'b1;
        tick();
        hdone[1] = 1'b0;
        valid[1] = 1'b0;
        repeat (3) tick();
        ack[1] = 1'b1;
        tick();
        ack[1] = 1'b0;
        tick();
        check("to_late_busy", 128'(o_busy[1]), 128'(0));
        check("to_late_rerr", 128'(o_rerr[1]), 128'(1));
        check("to_late_cmds", 128'(rd_rise[1] - r0), 128'(1));
        check("to_late_dones", 128'(dn_cnt[1] - d0), 128'(1));

        // Held valid: one command only until valid drops and rises again.
        r0 = rd_rise[0];
        start_req(0, 16'd3, 32'h8, 32'h4000, 32'h20);
        tick();
        ack[0] = 1'b1; hdone[0] = 1'b1;
        tick();
        ack[0] = 1'b0; hdone[0] = 1'b0;
        repeat (1000) tick();
        check("held_one_cmd", 128'(rd_rise[0] - r0), 128'(1));
        check("held_busy", 128'(o_busy[0]), 128'(1));
        valid[0] = 1'b0;
        repeat (3) tick();
        check("held_release", 128'(o_busy[0]), 128'(0));
        valid[0] = 1'b1;
        repeat (2) tick();
        check("held_second_cmd", 128'(rd_rise[0] - r0), 128'(2));
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0; hdone[0] = 1'b1;
        tick();
        hdone[0] = 1'b0;
        valid[0] = 1'b0;
        repeat (3) tick();

        // Reset while waiting for host done.
        start_req(0, 16'h1234, 32'hdead, 32'hbeef, 32'h99);
        tick();
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        repeat (5) tick();
        check("rw_busy", 128'(o_busy[0]), 128'(1));
        #1;
        reset_n  = 1'b0;
        valid[0] = 1'b0;
        #1;
        check("rw_read", 128'(o_read[0]), 128'(0));
        check("rw_busy_clr", 128'(o_busy[0]), 128'(0));
        check("rw_par", 128'({o_id[0], o_off[0], o_addr[0], o_len[0]}), 128'(0));
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        d0 = dn_cnt[0];
        start_req(0, 16'd9, 32'd0, 32'h500, 32'h0);
        tick();
        check("len0_issue", 128'(o_read[0]), 128'(1));
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        repeat (3) tick();
        hdone[0] = 1'b1;
        tick();
        hdone[0] = 1'b0;
        check("post_rst_done", 128'(o_done[0]), 128'(1));
        check("post_rst_rerr", 128'(o_rerr[0]), 128'(0));
        valid[0] = 1'b0;
        repeat (3) tick();
        check("post_rst_dones", 128'(dn_cnt[0] - d0), 128'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
